// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the combinational
// instruction memory address and hands fetched words to decode through a
// one-entry valid/ready output register. Handles redirects and end-of-image.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | fetching; capture a word whenever the output register is free
// DRAIN | PC past the image; wait for the last held word to be taken
// HALT  | fetch ended, output register empty, PC frozen
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] END_PC   = 64'h060
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] InstrAddr,
  input  logic [31:0] InstrData,
  output logic        IFValid,
  output logic [31:0] IFInstr,
  output logic [63:0] IFPC,
  input  logic        IFReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        handshake;
  logic        out_free;
  logic        pc_in_image;
  logic [63:0] redirect_target;

  assign handshake       = IFValid & IFReady;
  assign out_free        = ~IFValid | handshake;
  assign pc_in_image     = (pc < END_PC);
  // Low two bits dropped so a misaligned target lands on its word.
  assign redirect_target = RedirectPC & ~64'h3;

  // The address comes straight from the PC register, so it only moves on
  // an edge or on reset.
  assign InstrAddr = pc;

  // Fetch sequencer: PC, output register and state, with redirect on top.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      IFValid <= 1'b0;
      IFInstr <= 32'h0;
      IFPC    <= 64'h0;
      Halted  <= 1'b0;
    end else if (Redirect) begin
      // Held instruction is discarded; no capture in the redirect cycle.
      state   <= RUN;
      pc      <= redirect_target;
      IFValid <= 1'b0;
      Halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!pc_in_image) begin
            state <= DRAIN;
            if (handshake) begin
              IFValid <= 1'b0;
            end
          end else if (out_free) begin
            IFInstr <= InstrData;
            IFPC    <= pc;
            IFValid <= 1'b1;
            pc      <= pc + 64'd4;
          end
        end
        DRAIN: begin
          if (handshake || !IFValid) begin
            IFValid <= 1'b0;
            Halted  <= 1'b1;
            state   <= HALT;
          end
        end
        HALT: begin
          IFValid <= 1'b0;
          Halted  <= 1'b1;
        end
        default: begin
          state   <= RUN;
          IFValid <= 1'b0;
          Halted  <= 1'b0;
        end
      endcase
    end
  end

  // Count accepted handshakes, including one that coincides with a redirect.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      FetchCount <= 32'h0;
    end else if (handshake) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that sits directly upstream of the combinational `InstructionMemory` read port. It owns the program counter and drives the memory address. It registers the returned 32-bit instruction with its PC into a one-entry IF/ID output register, handed to decode over a valid/ready handshake. It also handles control-flow redirects (taken branch, CBZ, B) and stops fetching cleanly at the end of the loaded program image.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset.
- `END_PC`, 64'h060, first address not fetched; one past the last program word.
- `CLK`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `InstrAddr`  out  64  address to `InstructionMemory.Address`; combinationally equal to the PC register.
- `InstrData`  in  32  instruction from `InstructionMemory.Data`; sampled the same cycle.
- `IFValid`  out  1  output register holds a valid instruction.
- `IFInstr`  out  32  registered instruction.
- `IFPC`  out  64  address of `IFInstr`.
- `IFReady`  in  1  decode accepts `IFInstr` this cycle.
- `Redirect`  in  1  flush and restart fetch at `RedirectPC`.
- `RedirectPC`  in  64  redirect target; bits [1:0] are forced to 0.
- `Halted`  out  1  fetch has ended and the output register is empty.
- `FetchCount`  out  32  number of accepted handshakes (`IFValid & IFReady`); wraps mod 2^32.

## Operation
- Handshake:
  - A handshake occurs when `IFValid & IFReady`.
  - The output register is "free" when `!IFValid` or a handshake occurs.
- States:
  - RUN:
    - If `PC < END_PC` and the output register is free, capture `InstrData`/`PC` into the output register, set `IFValid=1`, and advance `PC <= PC + 4`.
    - If `PC >= END_PC`, go to DRAIN without capturing.
  - DRAIN:
    - No capture.
    - On a handshake, or if `IFValid=0`, clear `IFValid` and go to HALT.
  - HALT:
    - `Halted=1` and `IFValid=0`.
    - PC holds its value.
- Redirect:
  - Highest priority and legal in every state.
  - Effects on the next edge: `IFValid <= 0` (discards the held instruction), `PC <= {RedirectPC[63:2],2'b00}`, state <= RUN.
  - No capture occurs in the redirect cycle.
- A handshake in the same cycle as `Redirect` still counts: decode has taken that instruction, so `FetchCount` increments.
- Backpressure: while `IFValid=1` and `IFReady=0`, `IFInstr`, `IFPC`, `IFValid` and `PC` are held stable.
- PC arithmetic is 64-bit and wraps mod 2^64. `END_PC` prevents out-of-range (X) reads in normal use.
- `InstrAddr` never changes except on a clock edge or on reset.

## Timing
- Reset (asynchronous, immediate):
  - PC = `RESET_PC`, state RUN.
  - `IFValid=0`, `IFInstr=0`, `IFPC=0`, `Halted=0`, `FetchCount=0`.
  - `InstrAddr` = `RESET_PC`.
- Latency:
  - The address is presented in cycle N; the instruction is visible on `IFInstr` after edge N+1.
  - The first `IFValid=1` appears on the first rising edge after `Reset` deasserts.
- Throughput: one instruction per cycle with `IFReady` held high.
- Redirect penalty: one bubble cycle (`IFValid=0`). The target instruction is valid on the second edge after `Redirect` is sampled.
- End of program: `Halted` rises one edge after the handshake of the last instruction (PC = `END_PC`-4). If the RUN to DRAIN transition is still pending, `Halted` rises one edge later instead.
- Reset mid-operation: immediate return to reset values. Any in-flight instruction is lost, and `FetchCount` clears.

## Test plan
- Reset, then `IFReady=1` constantly: `IFPC` runs 0x0, 0x4, 0x8, … one per cycle. `IFInstr` is 32'hF84003E9 at 0x0, 32'hF84083EA at 0x4, 32'hAA0B014A at 0x14.
- Backpressure: `IFReady=0` for 3 cycles while `IFPC`=0x8.
  - Required: `IFInstr`=32'hF84103EB and `InstrAddr`=0xC are held stable.
  - When `IFReady` returns, the next `IFPC` is 0xC (32'hF84183EC) and there are no duplicates or drops.
- Redirect to 0x20 while `IFPC`=0x28 is valid and `IFReady=1`:
  - `FetchCount` increments for 0x28.
  - One bubble cycle follows.
  - Then `IFPC`=0x20, `IFInstr`=32'h8B0901AD, then 0x24 with 32'hCB09018C.
- Misaligned redirect to 0x26: the next valid `IFPC` is 0x24 with 32'hCB09018C.
- Full run to end with `IFReady=1`:
  - The last valid `IFPC` is 0x5C (32'hF841C3EA).
  - `Halted`=1 and `IFValid`=0 afterwards, and `FetchCount`=24.
  - A subsequent redirect to 0x0 clears `Halted` and refetches 32'hF84003E9.
- Assert `Reset` asynchronously mid-cycle while `IFPC`=0x30:
  - Outputs go to reset values immediately, without waiting for an edge.
  - After release, fetch restarts at 0x0 and `FetchCount` restarts from 0.
